// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : load_store_unit                                               |
// | Purpose  : Executes one RV32I load or store per request. Builds byte     |
// |            enables and lane-shifted store data, sign/zero-extends load   |
// |            data, splits word-boundary-crossing accesses into two word    |
// |            transactions and bounds every memory wait with a timeout.     |
// | Ports    : clk, rst               clock / sync active-high reset         |
// |            req_i, we_i, funct3_i, addr_i, wdata_i   request side         |
// |            busy_o, done_o, err_o, rdata_o           completion side      |
// |            mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,       |
// |            mem_ack_i, mem_rdata_i                   memory req/ack side  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module load_store_unit #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned ACK_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // The counter only has to hold 0..ACK_TIMEOUT-1; the timeout fires on the
  // no-ack cycle that would bring it to ACK_TIMEOUT.
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] c_tmo_last = TW'(ACK_TIMEOUT - 1);

  state_t        state_q;
  logic          busy_q, done_q, err_q;
  logic [31:0]   rdata_q;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [3:0]    mem_be_q;
  logic          we_q, split_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [3:0]    be_hi_q;
  logic [31:0]   wd_hi_q, lo_q;
  logic [TW-1:0] cnt_q;

  // Request decode, evaluated on the live inputs while idle.
  logic [3:0]  w_mask;
  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic        w_legal, w_split, w_reject;

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    w_be8  = {4'b0000, w_mask} << addr_i[1:0];
    w_wd64 = {32'd0, wdata_i} << {addr_i[1:0], 3'b000};
    w_split = |w_be8[7:4];
    if (we_i) begin
      w_legal = !funct3_i[2] && (funct3_i[1:0] != 2'b11);
    end else begin
      // loads: reject x11 (no such size) and 110 (no unsigned word load)
      w_legal = (funct3_i[1:0] != 2'b11) && !(funct3_i[2] && funct3_i[1]);
    end
    w_reject = !w_legal || (w_split && !ALLOW_MISALIGNED);
  end

  logic w_tmo;
  assign w_tmo = (ACK_TIMEOUT != 0) && !mem_ack_i && (cnt_q == c_tmo_last);

  // Shift the two captured words down by the byte offset, then extend.
  function automatic logic [31:0] load_result(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] hi,
                                              input logic [31:0] lo);
    logic [31:0] r;
    r = 32'({hi, lo} >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   load_result = f3[2] ? {24'd0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
      2'b01:   load_result = f3[2] ? {16'd0, r[15:0]} : {{16{r[15]}}, r[15:0]};
      default: load_result = r;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      be_hi_q     <= 4'd0;
      wd_hi_q     <= 32'd0;
      lo_q        <= 32'd0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            if (w_reject) begin
              // rejected without touching memory; FIN carries the error pulse
              state_q <= S_FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= S_ACC0;
              busy_q      <= 1'b1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= we_i;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_be_q    <= w_be8[3:0];
              mem_wdata_q <= w_wd64[31:0];
              we_q        <= we_i;
              funct3_q    <= funct3_i;
              off_q       <= addr_i[1:0];
              split_q     <= w_split;
              be_hi_q     <= w_be8[7:4];
              wd_hi_q     <= w_wd64[63:32];
              cnt_q       <= '0;
            end
          end
        end
        S_ACC0, S_ACC1: begin
          if (mem_ack_i) begin
            if ((state_q == S_ACC0) && split_q) begin
              // second word: keep mem_req high, advance to the next word
              state_q     <= S_ACC1;
              lo_q        <= mem_rdata_i;
              mem_addr_q  <= mem_addr_q + 32'd4;
              mem_be_q    <= be_hi_q;
              mem_wdata_q <= wd_hi_q;
              cnt_q       <= '0;
            end else begin
              state_q   <= S_FIN;
              busy_q    <= 1'b0;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              done_q    <= 1'b1;
              err_q     <= 1'b0;
              if (!we_q) begin
                rdata_q <= (state_q == S_ACC1)
                         ? load_result(funct3_q, off_q, mem_rdata_i, lo_q)
                         : load_result(funct3_q, off_q, 32'd0, mem_rdata_i);
              end
            end
          end else if (w_tmo) begin
            // abandon the access; rdata keeps its previous value
            state_q   <= S_FIN;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire
